// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one DWIDTH-bit word at a time and sends it as
// DWIDTH/8 back-to-back 8N1 UART frames, least-significant byte first.
module fifo_uart_tx #(
  parameter int DWIDTH       = 16,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DWIDTH-1:0] fifo_dout,
  output logic              tx,
  output logic              busy
);

  localparam int NBYTES = DWIDTH / 8;
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);
  localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state;
  logic [DWIDTH-1:0] shreg;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [BYTE_W-1:0] byte_idx;
  logic              bit_done;

  assign bit_done = (baud_cnt == LAST_BAUD);

  // NOTE: every register here, including tx and the FIFO strobe, is assigned
  // with <= so all next-state values are computed from the same pre-edge state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      shreg      <= '0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && !fifo_empty) begin
            state      <= POP;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end

        // The read request is on the FIFO port during this cycle; data
        // appears one cycle later, in LOAD.
        POP: state <= LOAD;

        LOAD: begin
          shreg    <= fifo_dout;
          byte_idx <= '0;
          baud_cnt <= '0;
          tx       <= 1'b0;
          state    <= START;
        end

        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shreg[0];
            shreg    <= {1'b0, shreg[DWIDTH-1:1]};
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        // After the eighth bit the word register has shifted a whole byte,
        // so bit 0 already holds the next byte's LSB.
        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[DWIDTH-1:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (byte_idx != LAST_BYTE) begin
              byte_idx <= byte_idx + BYTE_W'(1);
              tx       <= 1'b0;
              state    <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the synchronous FIFO: pops DWIDTH-bit words whenever the FIFO is non-empty and transmission is enabled. Serializes each word as DWIDTH/8 standard UART frames (8N1), least-significant byte first, on a single `tx` line. Sits between the FIFO read port and the board's UART pin. It is the only reader of that FIFO.

## Interface
- `DWIDTH`, 16: FIFO word width. Must be a multiple of 8; NBYTES = DWIDTH/8.
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥ 2.
- `clk` input 1: clock; all logic on the rising edge.
- `rstn` input 1: reset, asynchronous, active-low.
- `enable` input 1: permits starting a new word. Sampled only in IDLE.
- `fifo_empty` input 1: FIFO empty flag.
- `fifo_rd_en` output 1: FIFO read request. Single-cycle pulse per word.
- `fifo_dout` input DWIDTH: FIFO read data. Valid the cycle after the `fifo_rd_en` edge.
- `tx` output 1: UART serial line, idle high.
- `busy` output 1: high in every state except IDLE.

## Operation
- Reset (rstn low, asynchronous):
  - `tx`=1, `fifo_rd_en`=0, `busy`=0.
  - State=IDLE; all counters and the shift register cleared.
- States and transitions:
  - IDLE: on `enable`=1 and `fifo_empty`=0, go to POP; otherwise stay in IDLE.
  - POP: `fifo_rd_en`=1 for exactly this cycle, then go to LOAD.
  - LOAD: capture `fifo_dout` into the word register, set byte_idx=0, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: `tx` = byte[byte_idx] bit bit_idx, LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. Then, if byte_idx < NBYTES-1, increment byte_idx and go to START; else go to IDLE.
- Byte order: byte 0 = word[7:0] is sent first; byte NBYTES-1 = word[DWIDTH-1:DWIDTH-8] is sent last.
- Counters:
  - Baud counter runs 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary.
  - bit_idx is 3 bits; byte_idx is $clog2(NBYTES) bits, minimum 1.
- `fifo_rd_en` is never asserted when `fifo_empty`=1 in the IDLE decision cycle. No read is issued outside POP.
- Deasserting `enable` mid-word does not abort: the current word completes, and no further pop occurs.
- `fifo_dout` is ignored outside LOAD.
- Reset mid-frame: `tx` returns to 1 immediately and the in-flight word is discarded. No retransmission.

## Timing
- Latency, IDLE decision edge to start-bit first cycle: 2 cycles (POP, LOAD).
- Word duration, POP to end of last stop bit: 2 + NBYTES·10·CLKS_PER_BIT cycles.
- Bytes within a word are back-to-back: the stop bit is followed directly by the next start bit, with no idle gap.
- Back-to-back words: the cycle after the last stop bit ends is IDLE. If the FIFO is still non-empty, POP follows on the next cycle.
  - Inter-word gap on `tx`: 3 idle-high cycles (IDLE, POP, LOAD) beyond the stop bit.
- `busy` rises in POP and falls when IDLE is re-entered.
- `tx` is driven from a register; it is glitch-free.

## Test plan
- Reset: hold rstn=0 with `fifo_empty`=0 and `enable`=1 -> `tx`=1, `fifo_rd_en`=0, `busy`=0 throughout. Release reset -> POP occurs one cycle after the first IDLE evaluation.
- Single word, CLKS_PER_BIT=4, DWIDTH=16, word 0xA55A:
  - exactly one `fifo_rd_en` pulse;
  - `tx` = start 0, bits 0,1,0,1,1,0,1,0, stop 1;
  - then start 0, bits 1,0,1,0,0,1,0,1, stop 1;
  - each bit 4 cycles; `busy` high for 82 cycles.
- Two words 0x1234 then 0xFFFF queued:
  - decoded byte stream 0x34, 0x12, 0xFF, 0xFF;
  - exactly 2 read pulses;
  - 3-cycle idle-high gap between the words.
- Empty FIFO: `fifo_empty`=1 and `enable`=1 for 100 cycles -> no `fifo_rd_en`, `tx`=1, `busy`=0.
- Enable drop: deassert `enable` during the first byte of 0xBEEF -> both bytes 0xEF and 0xBE complete. No second pop even though `fifo_empty`=0.
- Mid-frame reset: assert rstn=0 during a DATA bit -> `tx`=1 asynchronously, before the next clock edge. After release, the next transmission starts with a fresh pop and sends no remnant of the old word.
